// File: rtl/seq_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter and the detector bench:
// FSM state encoding and default widths.
package seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SEND = 2'd1;
    localparam state_t ST_GAP  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    localparam int PAT_W_DEF = 16;
    localparam int LEN_W_DEF = 5;
    localparam int CNT_W_DEF = 4;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Control/stream bundle between a pattern transmitter and whoever drives it.
interface seq_pattern_tx_if #(
    parameter int PAT_W = seq_pkg::PAT_W_DEF,
    parameter int LEN_W = seq_pkg::LEN_W_DEF,
    parameter int CNT_W = seq_pkg::CNT_W_DEF
);
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] reps;
    logic             a;
    logic             a_vld;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] bit_idx;

    modport master (
        output start, abort, pattern, len, reps,
        input  a, a_vld, busy, done, bit_idx
    );

    modport slave (
        input  start, abort, pattern, len, reps,
        output a, a_vld, busy, done, bit_idx
    );
endinterface

// File: rtl/seq_pattern_tx_shift.sv
// Load/shift-left pattern register; the pattern is left-aligned on load so the
// bit to transmit is always the MSB of the word.
module pat_shift_reg #(
    parameter int PAT_W = seq_pkg::PAT_W_DEF,
    parameter int LEN_W = seq_pkg::LEN_W_DEF
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] load_word,
    input  logic [LEN_W-1:0] load_len,
    output logic             bit_out,
    output logic [LEN_W-1:0] idx
);
    logic [PAT_W-1:0] word;

    // load_len is never 0 or above PAT_W when load is asserted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word <= '0;
            idx  <= '0;
        end else if (load) begin
            word <= load_word << (LEN_W'(PAT_W) - load_len);
            idx  <= load_len - LEN_W'(1);
        end else if (shift) begin
            word <= {word[PAT_W-2:0], 1'b0};
            idx  <= idx - LEN_W'(1);
        end
    end

    assign bit_out = word[PAT_W-1];
endmodule

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: sends a latched word MSB-first, optionally
// repeated with a fixed idle gap, and pulses done after the last bit.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int PAT_W   = PAT_W_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int GAP_CYC = 2
)(
    input  logic             clk,
    input  logic             rst,
    seq_pattern_tx_if.slave  bus
);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        return (l > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : l;
    endfunction

    function automatic logic [CNT_W-1:0] floor_reps(input logic [CNT_W-1:0] r);
        return (r == '0) ? CNT_W'(1) : r;
    endfunction

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [CNT_W-1:0] reps_q;
    logic [GAP_W-1:0] gap_q;

    logic [LEN_W-1:0] eff_len;
    logic [CNT_W-1:0] eff_reps;
    logic             accept, last_bit, more_reps, gap_end;
    logic             load, shift;
    logic [PAT_W-1:0] load_word;
    logic [LEN_W-1:0] load_len;
    logic             bit_out;
    logic [LEN_W-1:0] idx;

    assign eff_len   = clamp_len(bus.len);
    assign eff_reps  = floor_reps(bus.reps);
    assign accept    = (state_q == ST_IDLE) && bus.start && !bus.abort;
    assign last_bit  = (idx == '0);
    assign more_reps = (reps_q > CNT_W'(1));
    assign gap_end   = (gap_q == GAP_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // abort overrides every other transition, including a simultaneous start
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.start) state_d = (eff_len == '0) ? ST_DONE : ST_SEND;
            ST_SEND: if (last_bit)
                         state_d = !more_reps ? ST_DONE :
                                   (GAP_CYC > 0) ? ST_GAP : ST_SEND;
            ST_GAP:  if (gap_end) state_d = ST_SEND;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (bus.abort) state_d = ST_IDLE;
    end

    always_comb begin
        bus.a       = (state_q == ST_SEND) ? bit_out : 1'b0;
        bus.a_vld   = (state_q == ST_SEND);
        bus.busy    = (state_q == ST_SEND) || (state_q == ST_GAP);
        bus.done    = (state_q == ST_DONE);
        bus.bit_idx = (state_q == ST_SEND) ? idx : '0;
    end

    // First load comes straight from the inputs; reloads come from the latched copy
    always_comb begin
        load = !bus.abort && (
                   (accept && eff_len != '0) ||
                   (state_q == ST_SEND && last_bit && more_reps && GAP_CYC == 0) ||
                   (state_q == ST_GAP && gap_end));
        shift     = (state_q == ST_SEND) && !last_bit;
        load_word = (state_q == ST_IDLE) ? bus.pattern : pat_q;
        load_len  = (state_q == ST_IDLE) ? eff_len     : len_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q  <= '0;
            len_q  <= '0;
            reps_q <= '0;
            gap_q  <= '0;
        end else begin
            if (accept) begin
                pat_q  <= bus.pattern;
                len_q  <= eff_len;
                reps_q <= eff_reps;
            end else if (state_q == ST_SEND && last_bit && more_reps) begin
                reps_q <= reps_q - CNT_W'(1);
            end
            gap_q <= (state_q == ST_GAP) ? gap_q + GAP_W'(1) : '0;
        end
    end

    pat_shift_reg #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .shift     (shift),
        .load_word (load_word),
        .load_len  (load_len),
        .bit_out   (bit_out),
        .idx       (idx)
    );
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: directed and random transfers compared cycle by
// cycle against an expected-stream queue built from the transfer rules.
module tb_seq_pattern_tx;
    import seq_pkg::*;

    localparam int PAT_W   = 16;
    localparam int LEN_W   = 5;
    localparam int CNT_W   = 4;
    localparam int GAP_CYC = 2;
    localparam int OW      = 4 + LEN_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [OW-1:0] expq[$];

    seq_pattern_tx_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    seq_pattern_tx #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP_CYC(GAP_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // packed view {a, a_vld, busy, done, bit_idx}
    function automatic logic [OW-1:0] pack(input bit a, input bit v, input bit b,
                                           input bit d, input int i);
        return {a, v, b, d, LEN_W'(i)};
    endfunction

    task automatic check(input string tag, input logic [OW-1:0] exp);
        logic [OW-1:0] obs;
        obs = {bus.a, bus.a_vld, bus.busy, bus.done, bus.bit_idx};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed a/vld/busy/done/idx=%b required %b", tag, obs, exp);
        end
    endtask

    // Expected output per cycle after the start edge, then one idle cycle.
    task automatic build(input logic [PAT_W-1:0] p, input int len, input int reps);
        int n;
        int r;
        n = (len > PAT_W) ? PAT_W : len;
        r = (reps == 0) ? 1 : reps;
        expq.delete();
        if (n > 0) begin
            for (int k = 0; k < r; k++) begin
                for (int i = n - 1; i >= 0; i--) expq.push_back(pack(p[i], 1, 1, 0, i));
                if (k < r - 1) repeat (GAP_CYC) expq.push_back(pack(0, 0, 1, 0, 0));
            end
        end
        expq.push_back(pack(0, 0, 0, 1, 0));
        expq.push_back(pack(0, 0, 0, 0, 0));
    endtask

    task automatic run_tx(input string tag, input logic [PAT_W-1:0] p, input int len,
                          input int reps, input int abort_at, input int restart_at);
        build(p, len, reps);
        @(negedge clk);
        bus.start = 1'b1; bus.pattern = p; bus.len = LEN_W'(len); bus.reps = CNT_W'(reps);
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.pattern = PAT_W'($urandom);
        bus.len     = LEN_W'($urandom);
        bus.reps    = CNT_W'($urandom);
        for (int i = 0; i < expq.size(); i++) begin
            check($sformatf("%s[%0d]", tag, i), expq[i]);
            if (i == abort_at) begin
                bus.abort = 1'b1;
                @(posedge clk); #1;
                bus.abort = 1'b0;
                repeat (4) begin
                    check({tag, "_abort"}, pack(0, 0, 0, 0, 0));
                    @(posedge clk); #1;
                end
                return;
            end
            if (i == restart_at) begin
                bus.start   = 1'b1;
                bus.pattern = PAT_W'($urandom);
                bus.len     = LEN_W'($urandom_range(1, PAT_W));
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.pattern = '0; bus.len = '0; bus.reps = '0;

        // reset, then quiet idle
        #4 check("in_reset", pack(0, 0, 0, 0, 0));
        #16 rst = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            check("idle", pack(0, 0, 0, 0, 0));
        end

        run_tx("p005d",   16'h005D, 9, 1, -1, -1);
        run_tx("p0005x2", 16'h0005, 3, 2, -1, -1);
        run_tx("len0",    16'hFFFF, 0, 1, -1, -1);
        run_tx("len20",   16'hB38E, 20, 1, -1, -1);
        run_tx("reps0",   16'h0006, 3, 0, -1, -1);
        run_tx("abort",   16'h005D, 9, 1, 3, -1);
        run_tx("after_abort", 16'h00A7, 8, 1, -1, -1);
        run_tx("restart", 16'h005D, 9, 1, -1, 3);
        run_tx("start_in_done", 16'h1234, 0, 1, -1, 0);
        run_tx("reps15",  16'h0002, 2, 15, -1, -1);

        // start and abort together in IDLE: nothing happens
        @(negedge clk);
        bus.start = 1'b1; bus.abort = 1'b1; bus.pattern = 16'hFFFF; bus.len = 5'd8; bus.reps = 4'd1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.abort = 1'b0;
        repeat (3) begin
            check("start_abort", pack(0, 0, 0, 0, 0));
            @(posedge clk); #1;
        end

        // asynchronous reset between edges mid-SEND
        build(16'hA5C3, 16, 1);
        @(negedge clk);
        bus.start = 1'b1; bus.pattern = 16'hA5C3; bus.len = 5'd16; bus.reps = 4'd1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("pre_rst[%0d]", i), expq[i]);
            @(posedge clk); #1;
        end
        #2 rst = 1'b0;
        #1 check("async_rst", pack(0, 0, 0, 0, 0));
        @(negedge clk) rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("post_rst", pack(0, 0, 0, 0, 0));
        end

        for (int t = 0; t < 8; t++)
            run_tx($sformatf("rnd%0d", t), PAT_W'($urandom), $urandom_range(0, 18),
                   $urandom_range(0, 3), -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
